sum_accumulator: RTL and testbench

Consumes the per-cycle scalar output of the vector summation stage (`sum` qualified by `readEn`) and accumulates a fixed number of partial sums into one full dot-product result. It sits directly downstream of the vector summation stage in the matrix multiply datapath. Row-by-column products longer than the summation stage's vector width are split into `NUM_PARTIALS` chunks. This block reassembles them and presents each completed result to the output writer through a valid/ready handshake.

---
 rtl/sum_accumulator.sv | 152 +++++++++++++++
 tb/tb_sum_accumulator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Reassembles NUM_PARTIALS consecutive partial sums from the vector summation
// stage into one full dot-product result. Each completed result is presented
// to the output writer through a valid/ready handshake.
//
// Ports:
//   Clock        - single clock, rising edge
//   Resetn       - synchronous active-low reset
//   sum          - unsigned partial sum (W_s bits), qualified by readEn
//   readEn       - single-cycle strobe, sum is valid this cycle
//   clear        - synchronous abort of the in-progress accumulation
//   inReady      - block would accept a strobe this cycle (monitoring only)
//   result       - completed accumulation (W_acc bits), registered
//   resultValid  - result is valid, held until resultReady is seen
//   resultReady  - downstream accepts result
//   dropped      - sticky flag, a strobe arrived while inReady was low
// ---------------------------------------------------------------------------
module sum_accumulator #(
    parameter int W_s          = 9,
    parameter int NUM_PARTIALS = 4,
    parameter int W_acc        = 11
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [W_s-1:0]   sum,
    input  logic             readEn,
    input  logic             clear,
    output logic             inReady,
    output logic [W_acc-1:0] result,
    output logic             resultValid,
    input  logic             resultReady,
    output logic             dropped
);

    localparam int CW = (NUM_PARTIALS > 1) ? $clog2(NUM_PARTIALS) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_PARTIALS - 1);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [W_acc-1:0] acc;
    logic [W_acc-1:0] acc_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [W_acc-1:0] result_next;
    logic             valid_next;
    logic             dropped_next;
    logic [W_acc-1:0] sum_ext;

    // Partial sums are unsigned, so widening is plain zero extension.
    assign sum_ext = W_acc'(sum);

    // While accumulating every strobe is taken; while a result is held a
    // strobe is only usable in the same cycle the downstream takes the result.
    assign inReady = (state == ACCUM) ? 1'b1 : resultReady;

    // Next-state and datapath decisions. Everything defaults to holding its
    // value, so idle cycles leave acc and count untouched. clear wins over
    // readEn and zeroes the partial work, but a result already held in HOLD
    // is left alone so it is still delivered. In HOLD, a strobe coinciding
    // with the handshake restarts accumulation with that sample rather than
    // losing it; with a single partial per result it becomes the next result
    // directly. A strobe with no handshake in HOLD is discarded and flagged.
    always_comb begin
        state_next   = state;
        acc_next     = acc;
        count_next   = count;
        result_next  = result;
        valid_next   = resultValid;
        dropped_next = dropped;

        case (state)
            ACCUM: begin
                if (clear) begin
                    acc_next   = '0;
                    count_next = '0;
                end else if (readEn) begin
                    if (count == LAST_COUNT) begin
                        result_next = acc + sum_ext;
                        acc_next    = '0;
                        count_next  = '0;
                        valid_next  = 1'b1;
                        state_next  = HOLD;
                    end else begin
                        acc_next   = acc + sum_ext;
                        count_next = count + CW'(1);
                    end
                end
            end

            HOLD: begin
                if (resultReady) begin
                    valid_next = 1'b0;
                    state_next = ACCUM;
                    if (clear) begin
                        acc_next   = '0;
                        count_next = '0;
                    end else if (readEn) begin
                        if (NUM_PARTIALS == 1) begin
                            result_next = sum_ext;
                            valid_next  = 1'b1;
                            state_next  = HOLD;
                        end else begin
                            acc_next   = sum_ext;
                            count_next = CW'(1);
                        end
                    end
                end else begin
                    if (clear) begin
                        acc_next   = '0;
                        count_next = '0;
                    end else if (readEn) begin
                        dropped_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ACCUM;
                acc_next   = '0;
                count_next = '0;
            end
        endcase
    end

    // State and datapath registers. Reset is synchronous and discards any
    // partial accumulation along with the held result and the sticky flag.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state       <= ACCUM;
            acc         <= '0;
            count       <= '0;
            result      <= '0;
            resultValid <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            state       <= state_next;
            acc         <= acc_next;
            count       <= count_next;
            result      <= result_next;
            resultValid <= valid_next;
            dropped     <= dropped_next;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator
//
// Directed bench for sum_accumulator with default parameters. A
// transaction-level model (a queue of accepted samples, a held result and a
// sticky drop flag) predicts outputs; a compare process checks the DUT
// against it on every falling edge, and literal expectations pin both the
// model and the DUT at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_sum_accumulator;

    localparam int W_s          = 9;
    localparam int NUM_PARTIALS = 4;
    localparam int W_acc        = 11;

    logic             Clock;
    logic             Resetn;
    logic [W_s-1:0]   sum;
    logic             readEn;
    logic             clear;
    logic             inReady;
    logic [W_acc-1:0] result;
    logic             resultValid;
    logic             resultReady;
    logic             dropped;

    int vectors;
    int miscompares;
    bit checkEn;

    int modelPartials[$];
    int modelResult;
    bit modelValid;
    bit modelDropped;

    sum_accumulator #(
        .W_s          (W_s),
        .NUM_PARTIALS (NUM_PARTIALS),
        .W_acc        (W_acc)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .sum         (sum),
        .readEn      (readEn),
        .clear       (clear),
        .inReady     (inReady),
        .result      (result),
        .resultValid (resultValid),
        .resultReady (resultReady),
        .dropped     (dropped)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got still running, expected finished");
        $fatal(1, "[TB] time limit reached");
    end

    // One comparison: counts a vector and reports a miscompare.
    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle's worth of inputs shortly after the rising edge.
    task automatic applyStimulus(input bit rstN, input bit clr, input bit re,
                                 input int s, input bit rr);
        @(posedge Clock);
        #1;
        Resetn      = rstN;
        clear       = clr;
        readEn      = re;
        sum         = W_s'(s);
        resultReady = rr;
    endtask

    task automatic strobe(input int s, input bit rr);
        applyStimulus(1'b1, 1'b0, 1'b1, s, rr);
    endtask

    task automatic idle(input bit rr);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, rr);
    endtask

    // Pin DUT and model together against a hand-computed value.
    task automatic checkResult(input string name, input int expResult, input bit expValid);
        checkOutput({name, "_result"}, int'(result), expResult);
        checkOutput({name, "_valid"}, int'(resultValid), int'(expValid));
        checkOutput({name, "_model"}, modelResult, expResult);
    endtask

    // Behavioural model: samples are collected while no result is pending
    // (or in the cycle the pending one is taken); once NUM_PARTIALS samples
    // are collected their total becomes the held result.
    always @(posedge Clock) begin
        if (!Resetn) begin
            modelPartials.delete();
            modelResult  = 0;
            modelValid   = 1'b0;
            modelDropped = 1'b0;
        end else begin
            bit accepting;
            accepting = !modelValid || resultReady;
            if (modelValid && resultReady) modelValid = 1'b0;
            if (clear) begin
                modelPartials.delete();
            end else if (readEn) begin
                if (accepting) begin
                    modelPartials.push_back(int'(sum));
                    if (modelPartials.size() == NUM_PARTIALS) begin
                        int total;
                        total = 0;
                        foreach (modelPartials[i]) total += modelPartials[i];
                        modelResult = total;
                        modelValid  = 1'b1;
                        modelPartials.delete();
                    end
                end else begin
                    modelDropped = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge Clock) begin
        if (checkEn) begin
            checkOutput("cyc_result", int'(result), modelResult);
            checkOutput("cyc_valid", int'(resultValid), int'(modelValid));
            checkOutput("cyc_dropped", int'(dropped), int'(modelDropped));
            checkOutput("cyc_inReady", int'(inReady), int'(!modelValid || resultReady));
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        checkEn     = 1'b0;
        Resetn      = 1'b0;
        clear       = 1'b0;
        readEn      = 1'b0;
        sum         = '0;
        resultReady = 1'b1;

        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
        idle(1'b1);
        checkEn = 1'b1;
        checkResult("reset", 0, 1'b0);
        checkOutput("reset_dropped", int'(dropped), 0);

        // Back-to-back: 4 x 16 with ready high, valid for exactly one cycle.
        repeat (4) strobe(16, 1'b1);
        idle(1'b1);
        checkResult("b2b", 64, 1'b1);
        idle(1'b1);
        checkOutput("b2b_one_cycle", int'(resultValid), 0);

        // Gapped: idle cycles do not advance the count.
        strobe(1, 1'b1);
        strobe(2, 1'b1);
        idle(1'b1);
        strobe(3, 1'b1);
        repeat (2) idle(1'b1);
        checkOutput("gap_no_early", int'(resultValid), 0);
        idle(1'b1);
        strobe(4, 1'b1);
        idle(1'b1);
        checkResult("gap", 10, 1'b1);
        idle(1'b1);

        // Max value without wrap, then a zero result.
        repeat (4) strobe(511, 1'b1);
        idle(1'b1);
        checkResult("max", 2044, 1'b1);
        repeat (4) strobe(0, 1'b1);
        idle(1'b1);
        checkResult("zero", 0, 1'b1);
        idle(1'b1);

        // Backpressure: result held through a stall, stray strobe is dropped.
        repeat (4) strobe(16, 1'b0);
        idle(1'b0);
        checkResult("bp_hold", 64, 1'b1);
        idle(1'b0);
        strobe(5, 1'b0);
        idle(1'b0);
        idle(1'b0);
        checkResult("bp_stall", 64, 1'b1);
        checkOutput("bp_dropped", int'(dropped), 1);
        idle(1'b1);
        repeat (4) strobe(1, 1'b1);
        idle(1'b1);
        checkResult("bp_next", 4, 1'b1);
        idle(1'b1);

        // Simultaneous accept and strobe: the 7 starts the next result.
        repeat (4) strobe(16, 1'b0);
        idle(1'b0);
        checkResult("sim_hold", 64, 1'b1);
        strobe(7, 1'b1);
        repeat (3) strobe(1, 1'b1);
        idle(1'b1);
        checkResult("sim", 10, 1'b1);
        idle(1'b1);

        // Reset mid-accumulation discards partials and clears dropped.
        repeat (2) strobe(16, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
        idle(1'b1);
        checkResult("rst_mid", 0, 1'b0);
        checkOutput("rst_mid_dropped", int'(dropped), 0);
        repeat (4) strobe(2, 1'b1);
        idle(1'b1);
        checkResult("rst_after", 8, 1'b1);
        idle(1'b1);

        // clear mid-accumulation: same outcome, dropped untouched.
        repeat (2) strobe(16, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 9, 1'b1);
        repeat (4) strobe(2, 1'b1);
        idle(1'b1);
        checkResult("clr_after", 8, 1'b1);
        checkOutput("clr_dropped", int'(dropped), 0);
        idle(1'b1);

        // clear while a result is held: result survives and is delivered.
        repeat (4) strobe(3, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 9, 1'b0);
        idle(1'b0);
        checkResult("clr_hold", 12, 1'b1);
        checkOutput("clr_hold_dropped", int'(dropped), 0);
        idle(1'b1);
        idle(1'b1);
        checkOutput("clr_hold_taken", int'(resultValid), 0);

        idle(1'b1);
        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
